rx_packet_ctrl: RTL and testbench

RX_PACKET_CTRL -- requirements
Module: rx_packet_ctrl

---
 rtl/rx_packet_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_rx_packet_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_packet_ctrl.sv
// rx_packet_ctrl: receives a CRC(4) / LEN(2) / payload(LEN) packet and writes the payload to memory.
// Optional feature macro RX_CHECKSUM_EN: CHECK compares a 32-bit additive payload sum with the CRC field.
module rx_packet_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 20832
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              START_RX,
    input  logic              ABORT,
    input  logic [7:0]        BYTE_IN,
    input  logic              BYTE_VALID,
    input  logic              PARITY_ERR,
    output logic              RTS,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [7:0]        MEM_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERROR,
    output logic [1:0]        ERR_CODE
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned MAX_LEN = (ADDR_W >= 16) ? 32'd65536 : (32'd1 << ADDR_W);

    typedef enum logic [2:0] {
        IDLE, HDR_CRC, HDR_LEN, PAYLOAD, CHECK, FINISH, ERR
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        hdr_cnt_q, hdr_cnt_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       pay_cnt_q, pay_cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              rts_q, rts_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_data_q, mem_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;
`ifdef RX_CHECKSUM_EN
    logic [31:0]       crc_q, crc_d;
    logic [31:0]       sum_q, sum_d;
`endif
    logic [15:0]       len_full;
    logic              active;

    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        len_d      = len_q;
        pay_cnt_d  = pay_cnt_q;
        tmo_d      = tmo_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        error_d    = error_q;
        err_code_d = err_code_q;
`ifdef RX_CHECKSUM_EN
        crc_d      = crc_q;
        sum_d      = sum_q;
`endif
        len_full   = {len_q[7:0], BYTE_IN};
        active     = (state_q == HDR_CRC) || (state_q == HDR_LEN) || (state_q == PAYLOAD);

        // ABORT outranks everything else in any non-idle state
        if (state_q != IDLE && ABORT) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (START_RX) begin
                state_d    = HDR_CRC;
                hdr_cnt_d  = '0;
                len_d      = '0;
                pay_cnt_d  = '0;
                tmo_d      = '0;
                error_d    = 1'b0;
                err_code_d = 2'd0;
`ifdef RX_CHECKSUM_EN
                crc_d      = '0;
                sum_d      = '0;
`endif
            end
        end else if (active) begin
            if (BYTE_VALID) begin
                tmo_d = '0;
                if (PARITY_ERR) begin
                    state_d    = ERR;
                    error_d    = 1'b1;
                    err_code_d = 2'd0;
                end else if (state_q == HDR_CRC) begin
`ifdef RX_CHECKSUM_EN
                    crc_d = {crc_q[23:0], BYTE_IN};
`endif
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd3) begin
                        state_d   = HDR_LEN;
                        hdr_cnt_d = '0;
                    end
                end else if (state_q == HDR_LEN) begin
                    len_d     = len_full;
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd1) begin
                        hdr_cnt_d = '0;
                        if (len_full == 16'd0) begin
                            state_d = CHECK;
                        end else if (32'(len_full) > MAX_LEN) begin
                            state_d    = ERR;
                            error_d    = 1'b1;
                            err_code_d = 2'd2;
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end
                end else begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = ADDR_W'(pay_cnt_q);
                    mem_data_d = BYTE_IN;
                    pay_cnt_d  = pay_cnt_q + 16'd1;
`ifdef RX_CHECKSUM_EN
                    sum_d = sum_q + 32'(BYTE_IN);
`endif
                    if (pay_cnt_q + 16'd1 == len_q) begin
                        state_d = CHECK;
                    end
                end
            end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                state_d    = ERR;
                error_d    = 1'b1;
                err_code_d = 2'd1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            case (state_q)
                CHECK: begin
`ifdef RX_CHECKSUM_EN
                    if (sum_q == crc_q) begin
                        state_d = FINISH;
                    end else begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        err_code_d = 2'd3;
                    end
`else
                    state_d = FINISH;
`endif
                end
                default: state_d = IDLE;
            endcase
        end

        // Status outputs are registered views of the next state
        rts_d  = (state_d == HDR_CRC) || (state_d == HDR_LEN) || (state_d == PAYLOAD);
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            hdr_cnt_q  <= '0;
            len_q      <= '0;
            pay_cnt_q  <= '0;
            tmo_q      <= '0;
            rts_q      <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'd0;
`ifdef RX_CHECKSUM_EN
            crc_q      <= '0;
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            len_q      <= len_d;
            pay_cnt_q  <= pay_cnt_d;
            tmo_q      <= tmo_d;
            rts_q      <= rts_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
`ifdef RX_CHECKSUM_EN
            crc_q      <= crc_d;
            sum_q      <= sum_d;
`endif
        end
    end

    assign RTS      = rts_q;
    assign MEM_WE   = mem_we_q;
    assign MEM_ADDR = mem_addr_q;
    assign MEM_DATA = mem_data_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERROR    = error_q;
    assign ERR_CODE = err_code_q;

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Scoreboard bench for rx_packet_ctrl: expected memory writes are queued as payload bytes are driven.
module tb_rx_packet_ctrl;

    localparam int ADDR_W = 8;
    localparam int TMO    = 64;

    logic              Clock;
    logic              Reset;
    logic              START_RX;
    logic              ABORT;
    logic [7:0]        BYTE_IN;
    logic              BYTE_VALID;
    logic              PARITY_ERR;
    logic              RTS;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [7:0]        MEM_DATA;
    logic              BUSY;
    logic              DONE;
    logic              ERROR;
    logic [1:0]        ERR_CODE;

    int vectors     = 0;
    int miscompares = 0;
    int we_cnt      = 0;
    int done_cnt    = 0;
    logic [ADDR_W+7:0] exp_q[$];
    logic [ADDR_W+7:0] mon_got;
    logic [ADDR_W+7:0] mon_want;

    rx_packet_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
        .Clock(Clock), .Reset(Reset), .START_RX(START_RX), .ABORT(ABORT),
        .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .PARITY_ERR(PARITY_ERR),
        .RTS(RTS), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .ERR_CODE(ERR_CODE)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Memory-write scoreboard and DONE counter, sampled mid-cycle
    always @(negedge Clock) begin
        if (MEM_WE === 1'b1) begin
            we_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL mem_write_unexpected got addr=%0h data=%0h required no write", MEM_ADDR, MEM_DATA);
            end else begin
                mon_got  = {MEM_ADDR, MEM_DATA};
                mon_want = exp_q.pop_front();
                if (mon_got !== mon_want) begin
                    miscompares++;
                    $display("FAIL mem_write got addr/data=%0h required %0h", mon_got, mon_want);
                end
            end
        end
        if (DONE === 1'b1) done_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clock); #1;
        end
    endtask

    task automatic start();
        START_RX = 1'b1;
        @(posedge Clock); #1;
        START_RX = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic perr);
        BYTE_IN    = b;
        BYTE_VALID = 1'b1;
        PARITY_ERR = perr;
        @(posedge Clock); #1;
        BYTE_VALID = 1'b0;
        PARITY_ERR = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] crc, input logic [15:0] len);
        send_byte(crc[31:24], 1'b0);
        send_byte(crc[23:16], 1'b0);
        send_byte(crc[15:8], 1'b0);
        send_byte(crc[7:0], 1'b0);
        idle(1);
        send_byte(len[15:8], 1'b0);
        send_byte(len[7:0], 1'b0);
    endtask

    task automatic send_payload_byte(input int idx, input logic [7:0] b);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(idx);
        exp_q.push_back({a, b});
        send_byte(b, 1'b0);
    endtask

    task automatic test_reset();
        int w0;
        Reset = 1'b1;
        idle(3);
        vectors++;
        if ({RTS, MEM_WE, BUSY, DONE, ERROR, ERR_CODE, MEM_ADDR, MEM_DATA} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got %0h required 0",
                     {RTS, MEM_WE, BUSY, DONE, ERROR, ERR_CODE, MEM_ADDR, MEM_DATA});
        end
        Reset = 1'b0;
        w0 = we_cnt;
        send_byte(8'hAA, 1'b0);
        idle(2);
        vectors++;
        if (BUSY !== 1'b0 || RTS !== 1'b0 || we_cnt != w0) begin
            miscompares++;
            $display("FAIL idle_byte_ignored got busy=%b rts=%b writes=%0d required 0 0 0", BUSY, RTS, we_cnt - w0);
        end
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_cnt;
        start();
        vectors++;
        if (RTS !== 1'b1 || BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_after_start got rts=%b busy=%b required 1 1", RTS, BUSY);
        end
        send_hdr(32'h0000_0006, 16'h0003);
        send_payload_byte(0, 8'h01);
        send_payload_byte(1, 8'h02);
        send_payload_byte(2, 8'h03);
        idle(3);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL basic_writes_missing got %0d pending required 0", exp_q.size());
        end
        vectors++;
        if (done_cnt - d0 != 1 || ERROR !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done got done=%0d error=%b required 1 0", done_cnt - d0, ERROR);
        end
    endtask

    task automatic test_checksum();
        int d0;
        d0 = done_cnt;
        start();
        send_hdr(32'h0000_0007, 16'h0003);
        send_payload_byte(0, 8'h01);
        send_payload_byte(1, 8'h02);
        send_payload_byte(2, 8'h03);
        idle(3);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL checksum_writes got %0d pending required 0", exp_q.size());
        end
`ifdef RX_CHECKSUM_EN
        vectors++;
        if (ERROR !== 1'b1 || ERR_CODE !== 2'd3 || done_cnt != d0) begin
            miscompares++;
            $display("FAIL checksum_mismatch got error=%b code=%0d done=%0d required 1 3 0", ERROR, ERR_CODE, done_cnt - d0);
        end
`else
        vectors++;
        if (ERROR !== 1'b0 || done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL checksum_disabled got error=%b done=%0d required 0 1", ERROR, done_cnt - d0);
        end
`endif
    endtask

    task automatic test_len_overflow();
        int w0;
        w0 = we_cnt;
        start();
        send_hdr(32'h0, 16'h0101);
        vectors++;
        if (ERROR !== 1'b1 || ERR_CODE !== 2'd2 || RTS !== 1'b0) begin
            miscompares++;
            $display("FAIL len_overflow got error=%b code=%0d rts=%b required 1 2 0", ERROR, ERR_CODE, RTS);
        end
        idle(3);
        vectors++;
        if (we_cnt != w0 || BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL len_overflow_quiet got writes=%0d busy=%b required 0 0", we_cnt - w0, BUSY);
        end
    endtask

    task automatic test_full_len();
        int w0, d0;
        logic [31:0] sum;
        logic [7:0]  b;
        w0  = we_cnt;
        d0  = done_cnt;
        sum = '0;
        for (int i = 0; i < 256; i++) sum = sum + 32'((i * 7 + 3) & 8'hFF);
        start();
        send_hdr(sum, 16'h0100);
        for (int i = 0; i < 256; i++) begin
            b = 8'((i * 7 + 3) & 8'hFF);
            send_payload_byte(i, b);
        end
        idle(4);
        vectors++;
        if (we_cnt - w0 != 256 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL full_len_writes got %0d writes, %0d pending required 256 0", we_cnt - w0, exp_q.size());
        end
        vectors++;
        if (done_cnt - d0 != 1 || ERROR !== 1'b0) begin
            miscompares++;
            $display("FAIL full_len_done got done=%0d error=%b required 1 0", done_cnt - d0, ERROR);
        end
    endtask

    task automatic test_timeout();
        start();
        send_hdr(32'h0, 16'h0005);
        send_payload_byte(0, 8'h5A);
        send_payload_byte(1, 8'hA5);
        idle(TMO - 1);
        vectors++;
        if (ERROR !== 1'b0 || BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_early got error=%b busy=%b required 0 1", ERROR, BUSY);
        end
        idle(1);
        vectors++;
        if (ERROR !== 1'b1 || ERR_CODE !== 2'd1) begin
            miscompares++;
            $display("FAIL timeout_code got error=%b code=%0d required 1 1", ERROR, ERR_CODE);
        end
        idle(2);
        vectors++;
        if (BUSY !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL timeout_idle got busy=%b pending=%0d required 0 0", BUSY, exp_q.size());
        end
    endtask

    task automatic test_parity();
        int w0;
        w0 = we_cnt;
        start();
        send_hdr(32'h0, 16'h0005);
        send_payload_byte(0, 8'h11);
        send_payload_byte(1, 8'h22);
        send_byte(8'h33, 1'b1);
        vectors++;
        if (ERROR !== 1'b1 || ERR_CODE !== 2'd0) begin
            miscompares++;
            $display("FAIL parity_code got error=%b code=%0d required 1 0", ERROR, ERR_CODE);
        end
        idle(3);
        vectors++;
        if (we_cnt - w0 != 2 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL parity_writes got %0d writes required 2", we_cnt - w0);
        end
        start();
        vectors++;
        if (ERROR !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_clear got error=%b required 0", ERROR);
        end
        ABORT = 1'b1;
        idle(1);
        ABORT = 1'b0;
        vectors++;
        if (BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_header got busy=%b required 0", BUSY);
        end
    endtask

    task automatic test_abort();
        int w0, d0;
        w0 = we_cnt;
        d0 = done_cnt;
        start();
        send_hdr(32'h0, 16'h0004);
        send_payload_byte(0, 8'h66);
        BYTE_IN    = 8'h77;
        BYTE_VALID = 1'b1;
        ABORT      = 1'b1;
        idle(1);
        BYTE_VALID = 1'b0;
        ABORT      = 1'b0;
        vectors++;
        if (BUSY !== 1'b0 || RTS !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle got busy=%b rts=%b required 0 0", BUSY, RTS);
        end
        idle(3);
        vectors++;
        if (we_cnt - w0 != 1 || done_cnt != d0 || ERROR !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_effects got writes=%0d done=%0d error=%b required 1 0 0", we_cnt - w0, done_cnt - d0, ERROR);
        end
    endtask

    task automatic test_reset_mid_payload();
        int w0, d0;
        start();
        send_hdr(32'h0, 16'h0004);
        send_payload_byte(0, 8'h9C);
        send_byte(8'hC9, 1'b0);
        Reset = 1'b1;
        #1;
        vectors++;
        if ({RTS, MEM_WE, BUSY, DONE, ERROR, ERR_CODE, MEM_ADDR, MEM_DATA} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_payload got %0h required 0",
                     {RTS, MEM_WE, BUSY, DONE, ERROR, ERR_CODE, MEM_ADDR, MEM_DATA});
        end
        @(posedge Clock); #1;
        Reset = 1'b0;
        w0 = we_cnt;
        d0 = done_cnt;
        idle(5);
        vectors++;
        if (we_cnt != w0 || done_cnt != d0 || BUSY !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_discard got writes=%0d done=%0d busy=%b pending=%0d required 0 0 0 0",
                     we_cnt - w0, done_cnt - d0, BUSY, exp_q.size());
        end
    endtask

    task automatic test_len_zero();
        int w0, d0;
        w0 = we_cnt;
        d0 = done_cnt;
        start();
        send_hdr(32'h0, 16'h0000);
        vectors++;
        if (DONE !== 1'b0 || BUSY !== 1'b1 || RTS !== 1'b0) begin
            miscompares++;
            $display("FAIL len_zero_check got done=%b busy=%b rts=%b required 0 1 0", DONE, BUSY, RTS);
        end
        idle(1);
        vectors++;
        if (DONE !== 1'b1) begin
            miscompares++;
            $display("FAIL len_zero_done got done=%b required 1", DONE);
        end
        idle(1);
        vectors++;
        if (DONE !== 1'b0 || BUSY !== 1'b0 || we_cnt != w0 || done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL len_zero_end got done=%b busy=%b writes=%0d pulses=%0d required 0 0 0 1",
                     DONE, BUSY, we_cnt - w0, done_cnt - d0);
        end
    endtask

    initial begin
        Reset      = 1'b1;
        START_RX   = 1'b0;
        ABORT      = 1'b0;
        BYTE_IN    = 8'h00;
        BYTE_VALID = 1'b0;
        PARITY_ERR = 1'b0;
        @(posedge Clock); #1;
        test_reset();
        test_basic();
        test_checksum();
        test_len_overflow();
        test_full_len();
        test_timeout();
        test_parity();
        test_abort();
        test_reset_mid_payload();
        test_len_zero();
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
